// File: rtl/epl_egr_rx_pkg.sv
// Shared definitions for the EPL egress receiver.
//   DEF_DATA_W / DEF_BYTES_W / DEF_DEPTH : default sizing constants
//   flit_t                               : one buffered flit at default widths
//   state_t                              : framing tracker states
package epl_egr_rx_pkg;

    localparam int unsigned DEF_DATA_W  = 512;
    localparam int unsigned DEF_BYTES_W = 6;
    localparam int unsigned DEF_DEPTH   = 8;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [DEF_BYTES_W-1:0] bytes;
        logic                   err;
    } flit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

endpackage

// File: rtl/epl_egr_rx_fifo.sv
// Synchronous flit FIFO with full/empty flags and same-cycle push/pop.
//   clk, rst    : clock, synchronous active-high reset (flushes the FIFO)
//   push, din   : write request and entry
//   pop         : remove the head entry (ignored when empty)
//   dout        : head entry, all-zero while empty
//   full, empty : occupancy flags
module epl_egr_rx_fifo
    import epl_egr_rx_pkg::*;
#(
    parameter type         ENTRY_T = flit_t,
    parameter int unsigned DEPTH   = DEF_DEPTH
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  ENTRY_T din,
    input  logic   pop,
    output ENTRY_T dout,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    ENTRY_T        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage is not reset; masking keeps the head all-zero until something is written.
    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/epl_egr_rx.sv
// EPL-side receiver for the egress-to-EPL link.
// Checks packet framing, buffers flits, returns one credit per freed entry and
// presents flits to the MAC over valid/ready.
//   clk, rst                         : clock, synchronous active-high reset
//   rx_valid/data/sop/eop/bytes/err  : flit from the egress transmit controller
//   credit_ret                       : one pulse per returned credit
//   mac_valid/ready/data/sop/eop/bytes/err : head flit towards the MAC
//   frm_err                          : pulse, cycle after a framing violation
//   ovf_err                          : sticky, a flit was dropped on a full FIFO
// Build option EPL_EGR_RX_STATS_EN adds stat_pkts, stat_frm, stat_drop counters.
module epl_egr_rx
    import epl_egr_rx_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned BYTES_W = DEF_BYTES_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [DATA_W-1:0]  rx_data,
    input  logic               rx_sop,
    input  logic               rx_eop,
    input  logic [BYTES_W-1:0] rx_bytes,
    input  logic               rx_err,
    output logic               credit_ret,
    output logic               mac_valid,
    input  logic               mac_ready,
    output logic [DATA_W-1:0]  mac_data,
    output logic               mac_sop,
    output logic               mac_eop,
    output logic [BYTES_W-1:0] mac_bytes,
    output logic               mac_err,
    output logic               frm_err,
    output logic               ovf_err
`ifdef EPL_EGR_RX_STATS_EN
    ,
    output logic [31:0]        stat_pkts,
    output logic [15:0]        stat_frm,
    output logic [15:0]        stat_drop
`endif
);

    localparam int unsigned PW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [BYTES_W-1:0] bytes;
        logic               err;
    } entry_t;

    state_t        state;
    logic          viol;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic          issue;
    logic [PW-1:0] pend;
    entry_t        wr_entry;
    entry_t        head;

    // A flit must open a packet in IDLE and must not reopen one in PKT.
    assign viol  = (state == IDLE) ? !rx_sop : rx_sop;
    assign pop   = mac_valid && mac_ready;
    assign push  = rx_valid && (!full || pop);
    assign drop  = rx_valid && full && !pop;
    assign issue = (pend != '0);

    always_comb begin
        wr_entry       = '0;
        wr_entry.data  = rx_data;
        wr_entry.sop   = rx_sop;
        wr_entry.eop   = rx_eop;
        wr_entry.bytes = rx_eop ? rx_bytes : '0;
        wr_entry.err   = rx_err || viol;
    end

    epl_egr_rx_fifo #(
        .ENTRY_T (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign mac_valid = !empty;
    assign mac_data  = head.data;
    assign mac_sop   = head.sop;
    assign mac_eop   = head.eop;
    assign mac_bytes = head.bytes;
    assign mac_err   = head.err;

    // Every flit moves the framing tracker, dropped ones included; eop always
    // closes the packet and anything else leaves one open.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            frm_err <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            if (rx_valid) begin
                state <= rx_eop ? IDLE : PKT;
            end
            frm_err <= rx_valid && viol;
            ovf_err <= ovf_err || drop;
        end
    end

    // pend counts credits owed to the sender; the credit being issued is taken
    // off in the same cycle so pend never goes negative.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= PW'(DEPTH);
            credit_ret <= 1'b0;
        end else begin
            pend       <= pend + PW'(pop) - PW'(issue);
            credit_ret <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (pend <= PW'(DEPTH));
        end
    end

`ifdef EPL_EGR_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts <= '0;
            stat_frm  <= '0;
            stat_drop <= '0;
        end else begin
            if (push && rx_eop) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (rx_valid && viol && (stat_frm != '1)) begin
                stat_frm <= stat_frm + 16'd1;
            end
            if (drop && (stat_drop != '1)) begin
                stat_drop <= stat_drop + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_epl_egr_rx.sv
// Self-checking bench for epl_egr_rx: a table of per-cycle vectors for
// packet flow and framing, plus hand-written overflow, full push/pop and
// mid-packet reset sequences.
module tb_epl_egr_rx;

    localparam int unsigned DATA_W  = 512;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned BYTES_W = 6;

    logic               clk;
    logic               rst;
    logic               rx_valid;
    logic [DATA_W-1:0]  rx_data;
    logic               rx_sop;
    logic               rx_eop;
    logic [BYTES_W-1:0] rx_bytes;
    logic               rx_err;
    logic               credit_ret;
    logic               mac_valid;
    logic               mac_ready;
    logic [DATA_W-1:0]  mac_data;
    logic               mac_sop;
    logic               mac_eop;
    logic [BYTES_W-1:0] mac_bytes;
    logic               mac_err;
    logic               frm_err;
    logic               ovf_err;
`ifdef EPL_EGR_RX_STATS_EN
    logic [31:0]        stat_pkts;
    logic [15:0]        stat_frm;
    logic [15:0]        stat_drop;
`endif

    int checks = 0;
    int errors = 0;

    epl_egr_rx #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .BYTES_W (BYTES_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_sop     (rx_sop),
        .rx_eop     (rx_eop),
        .rx_bytes   (rx_bytes),
        .rx_err     (rx_err),
        .credit_ret (credit_ret),
        .mac_valid  (mac_valid),
        .mac_ready  (mac_ready),
        .mac_data   (mac_data),
        .mac_sop    (mac_sop),
        .mac_eop    (mac_eop),
        .mac_bytes  (mac_bytes),
        .mac_err    (mac_err),
        .frm_err    (frm_err),
        .ovf_err    (ovf_err)
`ifdef EPL_EGR_RX_STATS_EN
        ,
        .stat_pkts  (stat_pkts),
        .stat_frm   (stat_frm),
        .stat_drop  (stat_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, sop, eop;
        logic [5:0]  bytes;
        logic        err, rdy;
        logic [31:0] tag;
        logic        e_mv, e_sop, e_eop;
        logic [5:0]  e_bytes;
        logic        e_err;
        logic [31:0] e_tag;
        logic        e_frm, e_cr;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mkv(input logic v, input logic s, input logic e,
                                 input logic [5:0] b, input logic er, input logic r,
                                 input logic [31:0] t, input logic emv, input logic es,
                                 input logic ee, input logic [5:0] eb, input logic eerr,
                                 input logic [31:0] et, input logic efrm, input logic ecr);
        vec_t x;
        x.v = v; x.sop = s; x.eop = e; x.bytes = b; x.err = er; x.rdy = r; x.tag = t;
        x.e_mv = emv; x.e_sop = es; x.e_eop = ee; x.e_bytes = eb; x.e_err = eerr;
        x.e_tag = et; x.e_frm = efrm; x.e_cr = ecr;
        return x;
    endfunction

    function automatic logic [DATA_W-1:0] pat(input logic [31:0] tag);
        return {16{tag}};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of rx inputs, then sample #1 after the edge.
    task automatic step(input logic v, input logic s, input logic e,
                        input logic [5:0] b, input logic er, input logic [31:0] tag);
        rx_valid = v;
        rx_sop   = s;
        rx_eop   = e;
        rx_bytes = b;
        rx_err   = er;
        rx_data  = pat(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
    endtask

    // Drain with mac_ready=1, expecting consecutive tags from 'first'.
    task automatic drain(input string nm, input logic [31:0] first, input int exp_n, input int exp_cr);
        int n;
        int cr;
        n  = 0;
        cr = 0;
        mac_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (mac_valid) begin
                chk($sformatf("%s data[%0d]", nm, n), mac_data, pat(first + 32'(n)));
                n++;
            end
            idle(1);
            if (credit_ret) cr++;
        end
        chk({nm, " flit count"}, DATA_W'(n), DATA_W'(exp_n));
        chk({nm, " credit count"}, DATA_W'(cr), DATA_W'(exp_cr));
        chk({nm, " empty after"}, DATA_W'(mac_valid), '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        rx_sop    = 1'b0;
        rx_eop    = 1'b0;
        rx_bytes  = '0;
        rx_err    = 1'b0;
        mac_ready = 1'b0;

        // Packet flow (v0-v5) and framing errors (v6-v13), starting with
        // the FIFO empty, FSM idle and all reset credits already returned.
        vecs[0]  = mkv(1,1,0,0,0,1,32'hA0,  1,1,0,0,0,32'hA0, 0,0);
        vecs[1]  = mkv(1,0,0,0,0,1,32'hA1,  1,0,0,0,0,32'hA1, 0,0);
        vecs[2]  = mkv(1,0,1,5,0,1,32'hA2,  1,0,1,5,0,32'hA2, 0,1);
        vecs[3]  = mkv(0,0,0,0,0,1,32'h0,   0,0,0,0,0,32'h0,  0,1);
        vecs[4]  = mkv(0,0,0,0,0,1,32'h0,   0,0,0,0,0,32'h0,  0,1);
        vecs[5]  = mkv(0,0,0,0,0,1,32'h0,   0,0,0,0,0,32'h0,  0,0);
        vecs[6]  = mkv(1,0,1,3,0,1,32'hB0,  1,0,1,3,1,32'hB0, 1,0);
        vecs[7]  = mkv(0,0,0,0,0,1,32'h0,   0,0,0,0,0,32'h0,  0,0);
        vecs[8]  = mkv(1,1,0,0,0,1,32'hB1,  1,1,0,0,0,32'hB1, 0,1);
        vecs[9]  = mkv(1,1,0,0,0,1,32'hB2,  1,1,0,0,1,32'hB2, 1,0);
        vecs[10] = mkv(1,0,1,0,1,1,32'hB3,  1,0,1,0,1,32'hB3, 0,1);
        vecs[11] = mkv(0,0,0,0,0,1,32'h0,   0,0,0,0,0,32'h0,  0,1);
        vecs[12] = mkv(0,0,0,0,0,1,32'h0,   0,0,0,0,0,32'h0,  0,1);
        vecs[13] = mkv(0,0,0,0,0,1,32'h0,   0,0,0,0,0,32'h0,  0,0);

        // Reset state.
        idle(2);
        chk("rst credit_ret", DATA_W'(credit_ret), '0);
        chk("rst mac_valid",  DATA_W'(mac_valid),  '0);
        chk("rst frm_err",    DATA_W'(frm_err),    '0);
        chk("rst ovf_err",    DATA_W'(ovf_err),    '0);
        chk("rst mac_data",   mac_data,            '0);
        chk("rst mac_fields", DATA_W'({mac_sop, mac_eop, mac_bytes, mac_err}), '0);

        // Reset release: exactly DEPTH back-to-back credits.
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            chk($sformatf("init credit[%0d]", i), DATA_W'(credit_ret), DATA_W'(i < 8));
            chk($sformatf("init mac_valid[%0d]", i), DATA_W'(mac_valid), '0);
        end

        for (int i = 0; i < 14; i++) begin
            mac_ready = vecs[i].rdy;
            step(vecs[i].v, vecs[i].sop, vecs[i].eop, vecs[i].bytes, vecs[i].err, vecs[i].tag);
            chk($sformatf("v%0d mac_valid", i), DATA_W'(mac_valid), DATA_W'(vecs[i].e_mv));
            chk($sformatf("v%0d mac_sop", i),   DATA_W'(mac_sop),   DATA_W'(vecs[i].e_sop));
            chk($sformatf("v%0d mac_eop", i),   DATA_W'(mac_eop),   DATA_W'(vecs[i].e_eop));
            chk($sformatf("v%0d mac_bytes", i), DATA_W'(mac_bytes), DATA_W'(vecs[i].e_bytes));
            chk($sformatf("v%0d mac_err", i),   DATA_W'(mac_err),   DATA_W'(vecs[i].e_err));
            chk($sformatf("v%0d mac_data", i),  mac_data, vecs[i].e_mv ? pat(vecs[i].e_tag) : '0);
            chk($sformatf("v%0d frm_err", i),   DATA_W'(frm_err),   DATA_W'(vecs[i].e_frm));
            chk($sformatf("v%0d credit", i),    DATA_W'(credit_ret), DATA_W'(vecs[i].e_cr));
            chk($sformatf("v%0d ovf_err", i),   DATA_W'(ovf_err),   '0);
        end

        // Overflow: fill with the MAC stalled, ninth flit is dropped.
        mac_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, i == 7, (i == 7) ? 6'd7 : 6'd0, 1'b0, 32'h20 + 32'(i));
        end
        chk("ovf full mac_valid", DATA_W'(mac_valid), 1);
        chk("ovf full head",      mac_data, pat(32'h20));
        chk("ovf before drop",    DATA_W'(ovf_err), '0);
        step(1'b1, 1'b1, 1'b1, 6'd1, 1'b0, 32'h28);
        chk("ovf set",            DATA_W'(ovf_err), 1);
        chk("ovf no frm_err",     DATA_W'(frm_err), '0);
        idle(1);
        chk("ovf sticky",         DATA_W'(ovf_err), 1);
        drain("ovf drain", 32'h20, 8, 8);
        chk("ovf sticky after drain", DATA_W'(ovf_err), 1);

        // Full FIFO with a pop and a push in the same cycle.
        do_reset();
        chk("pp ovf cleared", DATA_W'(ovf_err), '0);
        mac_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, i == 7, 6'd0, 1'b0, 32'h30 + 32'(i));
        end
        mac_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1, 6'd9, 1'b0, 32'h38);
        chk("pp no drop",      DATA_W'(ovf_err), '0);
        chk("pp head",         mac_data, pat(32'h31));
        chk("pp pend after pop", DATA_W'(dut.pend), 1);
        idle(1);
        chk("pp pend pop+ret", DATA_W'(dut.pend), 1);
        chk("pp credit",       DATA_W'(credit_ret), 1);
        drain("pp drain", 32'h32, 7, 8);
        chk("pp no drop end",  DATA_W'(ovf_err), '0);

        // Reset in the middle of a packet with four flits queued.
        do_reset();
        mac_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, 1'b0, 6'd0, 1'b0, 32'h40 + 32'(i));
        end
        chk("mr queued", DATA_W'(mac_valid), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mr mac_valid", DATA_W'(mac_valid), '0);
        chk("mr mac_data",  mac_data, '0);
        chk("mr credit",    DATA_W'(credit_ret), '0);
        begin
            int cr;
            step(1'b1, 1'b0, 1'b1, 6'd2, 1'b0, 32'h44);
            chk("mr frm_err",   DATA_W'(frm_err), 1);
            chk("mr head",      mac_data, pat(32'h44));
            chk("mr head err",  DATA_W'(mac_err), 1);
            cr = credit_ret ? 1 : 0;
            for (int i = 0; i < 11; i++) begin
                idle(1);
                if (credit_ret) cr++;
            end
            chk("mr credits", DATA_W'(cr), 8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
